// File: rtl/b4_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic engines.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package b4_arith_pkg;

  // Control FSM encoding for the serial subtractor
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to count 0..w-1 serial steps
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  // Counter width for the default operand width
  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin with borrow-out.
// Latency: purely combinational, zero cycles.
// Backpressure: none (no state, no handshake).
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  // Borrow out when a is 0 and b is 1, or when a==b and a borrow is pending
  always_comb begin
    d_o    = a_i ^ b_i ^ bin_i;
    bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
  end

endmodule

// File: rtl/b4_serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first through one full-subtractor cell.
// Latency: accept at edge N, out_valid first high after edge N+WIDTH; one result per WIDTH+2 cycles max.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. SUB_OVF_EN adds the ovf port.
module b4_serial_subtractor
  import b4_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CNT_BITS = cnt_width(WIDTH);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

  sub_state_e          state_q, state_d;
  logic [WIDTH-1:0]    a_sh_q, a_sh_d;
  logic [WIDTH-1:0]    b_sh_q, b_sh_d;
  logic [WIDTH-1:0]    diff_sh_q, diff_sh_d;
  logic                brw_q, brw_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                fs_d, fs_bout;
`ifdef SUB_OVF_EN
  logic                ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .bin_i  (brw_q),
    .d_o    (fs_d),
    .bout_o (fs_bout)
  );

  // State and datapath registers; reset clears everything and abandons any partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      brw_q     <= 1'b0;
      cnt_q     <= '0;
`ifdef SUB_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      brw_q     <= brw_d;
      cnt_q     <= cnt_d;
`ifdef SUB_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  // Next-state logic: load in IDLE, one bit per cycle in SHIFT, hold result in DONE
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    brw_d     = brw_q;
    cnt_d     = cnt_q;
`ifdef SUB_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = b;
          brw_d     = bin;
          cnt_d     = '0;
          diff_sh_d = '0;
`ifdef SUB_OVF_EN
          ovf_d     = 1'b0;
`endif
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        diff_sh_d = {fs_d, diff_sh_q[WIDTH-1:1]};
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        brw_d     = fs_bout;
        cnt_d     = cnt_q + CNT_BITS'(1);
        if (cnt_q == LAST_CNT) begin
`ifdef SUB_OVF_EN
          // brw_q is the borrow into the MSB during the last step
          ovf_d   = brw_q ^ fs_bout;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake and result outputs; diff/bout keep the last result until the next load
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    diff      = diff_sh_q;
    bout      = brw_q;
`ifdef SUB_OVF_EN
    ovf       = ovf_q;
`endif
  end

endmodule

// File: tb/tb_b4_serial_subtractor.sv
// Self-checking bench for b4_serial_subtractor (WIDTH=4) with an expected-result queue.
// Latency: checks out_valid arrives WIDTH cycles after acceptance.
// Backpressure: exercises held results, ignored in_valid in DONE, and reset mid-SHIFT.
module tb_b4_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  b4_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef SUB_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arithmetic in plain integers
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    exp_t m;
    int d, sa, sbv, sd;
    d   = int'(av) - int'(bv) - int'(bi);
    m.d = d[W-1:0];
    m.b = (d < 0);
    sa  = av[W-1] ? int'(av) - (1 << W) : int'(av);
    sbv = bv[W-1] ? int'(bv) - (1 << W) : int'(bv);
    sd  = sa - sbv - int'(bi);
    m.o = (sd < -(1 << (W-1))) || (sd > (1 << (W-1)) - 1);
    return m;
  endfunction

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    int t;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    sb.push_back(model(av, bv, bi));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input int hold);
    int   t;
    exp_t e;
    chk("busy_in_shift", {31'd0, busy}, 32'd1);
    chk("in_ready_in_shift", {31'd0, in_ready}, 32'd0);
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    chk("latency", t, W);
    if (sb.size() == 0) begin
      chk("unexpected_output", sb.size(), 1);
      return;
    end
    e = sb.pop_front();
    chk("diff", {28'd0, diff}, {28'd0, e.d});
    chk("bout", {31'd0, bout}, {31'd0, e.b});
`ifdef SUB_OVF_EN
    chk("ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
    // Stall downstream while poking in_valid, which must be ignored
    for (int i = 0; i < hold; i++) begin
      a        = W'($urandom);
      b        = W'($urandom);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_diff", {28'd0, diff}, {28'd0, e.d});
      chk("hold_bout", {31'd0, bout}, {31'd0, e.b});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_diff_held", {28'd0, diff}, {28'd0, e.d});
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_diff"}, {28'd0, diff}, 32'd0);
    chk({tag, "_bout"}, {31'd0, bout}, 32'd0);
`ifdef SUB_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_valid;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;

    // Reset held two cycles
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Directed cases, including both boundaries and the overflow case
    send(4'd9, 4'd3, 1'b0);  recv(0);
    send(4'd0, 4'd15, 1'b1); recv(0);
    send(4'd8, 4'd1, 1'b0);  recv(0);
    send(4'd7, 4'd7, 1'b0);  recv(0);
    send(4'd12, 4'd5, 1'b1); recv(6);

    // Abort on the second SHIFT cycle
    a        = 4'd15;
    b        = 4'd1;
    bin      = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("abort");
    seen_valid = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    chk("abort_no_valid", {31'd0, seen_valid}, 32'd0);
    send(4'd5, 4'd5, 1'b0); recv(0);

    // Random traffic with random downstream stalls
    for (int n = 0; n < 16; n++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
      recv(int'($urandom_range(0, 2)));
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
